// File: rtl/led_seq_pkg.sv
// Shared types and register map for the LED pattern sequencer.
// Register offsets, STATUS bit positions, pattern modes and FSM states.
package led_seq_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PERIOD = 2'd1;
   localparam logic [1:0] REG_SEED   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int ST_BUSY = 0;
   localparam int ST_DIR  = 1;
   localparam int ST_CUR  = 16;

   typedef enum logic [1:0] {
      M_STATIC = 2'd0,
      M_ROTATE = 2'd1,
      M_BOUNCE = 2'd2,
      M_BLINK  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_WAIT  = 2'd2,
      S_STEP  = 2'd3
   } state_e;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Avalon-MM config slave and LED PIO master port of the sequencer.
// master: the sequencer; slave: the CPU and PIO side.
interface led_pattern_sequencer_if;

   logic [1:0]  s_address;
   logic        s_chipselect;
   logic        s_write_n;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;

   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic        m_waitrequest;

   modport master (
      input  s_address, s_chipselect, s_write_n, s_writedata,
      input  m_waitrequest,
      output s_readdata,
      output m_address, m_chipselect, m_write_n, m_writedata
   );

   modport slave (
      output s_address, s_chipselect, s_write_n, s_writedata,
      output m_waitrequest,
      input  s_readdata,
      input  m_address, m_chipselect, m_write_n, m_writedata
   );

endinterface

// File: rtl/led_tick_gen.sv
// Step-period prescaler: counts 0..period while enabled, ticks at the top.
// >= guards against PERIOD being lowered below the running count.
module led_tick_gen #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] period,
   output logic         tick
);

   logic [W-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q >= period);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Autonomous LED pattern sequencer: CPU-programmed, writes successive
// patterns to the LEDR PIO data register over an Avalon-MM master.
module led_pattern_sequencer
   import led_seq_pkg::*;
#(
   parameter int                DATA_W        = 10,
   parameter int                PRESCALE_W    = 24,
   parameter logic [DATA_W-1:0] RESET_PATTERN = 10'h255
) (
   input  logic                    clk,
   input  logic                    reset_n,
   led_pattern_sequencer_if.master bus
);

   state_e                state_q, state_d;
   mode_e                 mode_q, mode_d;
   logic                  en_q, en_d;
   logic [PRESCALE_W-1:0] period_q, period_d;
   logic [DATA_W-1:0]     seed_q, seed_d;
   logic [DATA_W-1:0]     cur_q, cur_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic                  dir_q, dir_d;
   logic                  pend_q, pend_d;

   logic [DATA_W-1:0] nxt;
   logic              ndir;
   logic              wr;
   logic              seed_wr;
   logic              accept;
   logic              wait_en;
   logic              tick;
   logic [31:0]       rdata;
   logic              unused_wdata;

   assign wr      = bus.s_chipselect && !bus.s_write_n;
   assign seed_wr = wr && (bus.s_address == REG_SEED);
   assign accept  = (state_q == S_WRITE) && !bus.m_waitrequest;
   assign wait_en = (state_q == S_WAIT);
   assign unused_wdata = ^bus.s_writedata[31:PRESCALE_W];

   led_tick_gen #(.W(PRESCALE_W)) u_tick (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (accept),
      .en     (wait_en),
      .period (period_q),
      .tick   (tick)
   );

   always_comb begin
      nxt  = cur_q;
      ndir = dir_q;
      unique case (mode_q)
         M_STATIC: nxt = seed_q;
         M_ROTATE: nxt = {cur_q[DATA_W-2:0], cur_q[DATA_W-1]};
         M_BOUNCE: begin
            if (!dir_q) begin
               if (cur_q[DATA_W-1]) begin
                  ndir = 1'b1;
                  nxt  = cur_q >> 1;
               end else begin
                  nxt = cur_q << 1;
               end
            end else begin
               if (cur_q[0]) begin
                  ndir = 1'b0;
                  nxt  = cur_q << 1;
               end else begin
                  nxt = cur_q >> 1;
               end
            end
         end
         M_BLINK: nxt = (cur_q != '0) ? '0 : seed_q;
         default: nxt = cur_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      en_d     = en_q;
      period_d = period_q;
      seed_d   = seed_q;
      cur_d    = cur_q;
      wdata_d  = wdata_q;
      dir_d    = dir_q;
      pend_d   = pend_q;

      if (wr) begin
         unique case (bus.s_address)
            REG_CTRL: begin
               en_d   = bus.s_writedata[0];
               mode_d = mode_e'(bus.s_writedata[2:1]);
            end
            REG_PERIOD: period_d = bus.s_writedata[PRESCALE_W-1:0];
            REG_SEED:   seed_d   = bus.s_writedata[DATA_W-1:0];
            default:    ;
         endcase
      end

      unique case (state_q)
         S_IDLE: begin
            if (en_q) begin
               state_d = S_WRITE;
               wdata_d = cur_q;
            end
         end
         S_WRITE: begin
            if (accept) begin
               state_d = en_q ? S_WAIT : S_IDLE;
            end
         end
         S_WAIT: begin
            // STATIC already showing SEED: keep the bus idle
            if (!en_q) begin
               state_d = S_IDLE;
            end else if (tick &&
                         !(mode_q == M_STATIC && cur_q == seed_q)) begin
               state_d = S_STEP;
            end
         end
         S_STEP: begin
            cur_d   = nxt;
            dir_d   = ndir;
            wdata_d = nxt;
            state_d = S_WRITE;
         end
         default: state_d = S_IDLE;
      endcase

      // a new seed is held back while a write is in flight
      if (seed_wr) begin
         if (state_q == S_WRITE) begin
            pend_d = 1'b1;
         end else begin
            cur_d  = bus.s_writedata[DATA_W-1:0];
            dir_d  = 1'b0;
            pend_d = 1'b0;
         end
      end else if (pend_q && state_q != S_WRITE) begin
         cur_d  = seed_q;
         dir_d  = 1'b0;
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         mode_q   <= M_STATIC;
         en_q     <= 1'b0;
         period_q <= '0;
         seed_q   <= RESET_PATTERN;
         cur_q    <= RESET_PATTERN;
         wdata_q  <= '0;
         dir_q    <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         en_q     <= en_d;
         period_q <= period_d;
         seed_q   <= seed_d;
         cur_q    <= cur_d;
         wdata_q  <= wdata_d;
         dir_q    <= dir_d;
         pend_q   <= pend_d;
      end
   end

   always_comb begin
      rdata = '0;
      unique case (bus.s_address)
         REG_CTRL:   rdata[2:0] = {mode_q, en_q};
         REG_PERIOD: rdata[PRESCALE_W-1:0] = period_q;
         REG_SEED:   rdata[DATA_W-1:0] = seed_q;
         REG_STATUS: begin
            rdata[ST_BUSY]           = (state_q != S_IDLE);
            rdata[ST_DIR]            = dir_q;
            rdata[ST_CUR +: DATA_W]  = cur_q;
         end
         default: rdata = '0;
      endcase
   end

   assign bus.s_readdata   = rdata;
   assign bus.m_address    = 2'd0;
   assign bus.m_chipselect = (state_q == S_WRITE);
   assign bus.m_write_n    = (state_q != S_WRITE);
   assign bus.m_writedata  = {{(32-DATA_W){1'b0}}, wdata_q};

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Testbench for led_pattern_sequencer: register table, directed
// sequences and randomized runs against a pattern model.
module tb_led_pattern_sequencer;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   wr_mode = 0;

   logic [31:0] acc_q[$];
   int          acc_cyc[$];
   logic        stall_seen = 1'b0;
   logic [31:0] stall_data = '0;

   led_pattern_sequencer_if bus();

   led_pattern_sequencer dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // waitrequest: 0 = ready, 1 = random stalls, 2 = held stalled
   always @(posedge clk) begin
      #1;
      case (wr_mode)
         0:       bus.m_waitrequest = 1'b0;
         1:       bus.m_waitrequest = ($urandom_range(0, 2) == 0);
         default: bus.m_waitrequest = 1'b1;
      endcase
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.m_chipselect && !bus.m_write_n) begin
         if (stall_seen) chk("wdata_stable", bus.m_writedata, stall_data);
         if (bus.m_waitrequest) begin
            stall_seen = 1'b1;
            stall_data = bus.m_writedata;
         end else begin
            stall_seen = 1'b0;
            acc_q.push_back(bus.m_writedata);
            acc_cyc.push_back(cyc);
         end
      end else begin
         stall_seen = 1'b0;
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic reg_write(logic [1:0] a, logic [31:0] d);
      bus.s_address    = a;
      bus.s_writedata  = d;
      bus.s_chipselect = 1'b1;
      bus.s_write_n    = 1'b0;
      step();
      bus.s_chipselect = 1'b0;
      bus.s_write_n    = 1'b1;
   endtask

   task automatic reg_read(logic [1:0] a, output logic [31:0] d);
      bus.s_address    = a;
      bus.s_chipselect = 1'b1;
      bus.s_write_n    = 1'b1;
      #1;
      d = bus.s_readdata;
      bus.s_chipselect = 1'b0;
   endtask

   task automatic wait_acc(int n, int budget);
      while (acc_q.size() < n && budget > 0) begin
         step();
         budget--;
      end
      if (acc_q.size() < n) begin
         checks++;
         errors++;
         $display("FAIL wait_acc: got %0d writes, need %0d", acc_q.size(), n);
      end
   endtask

   task automatic wait_cs(int budget);
      while (!bus.m_chipselect && budget > 0) begin
         step();
         budget--;
      end
      if (!bus.m_chipselect) begin
         checks++;
         errors++;
         $display("FAIL wait_cs: no master request seen, need 1");
      end
   endtask

   task automatic stop_seq();
      logic [31:0] rd;
      int b = 0;
      wr_mode = 0;
      reg_write(2'd0, 32'h0);
      do begin
         reg_read(2'd3, rd);
         step();
         b++;
      end while (rd[0] && b < 50);
      if (rd[0]) begin
         checks++;
         errors++;
         $display("FAIL stop_seq: busy=1 need 0");
      end
      acc_q.delete();
      acc_cyc.delete();
   endtask

   // reference pattern rules, on plain integers
   function automatic void model_step(input int mode, inout int cur,
                                      inout int dir, input int seed);
      case (mode)
         0: cur = seed;
         1: cur = ((cur * 2) % 1024) + (cur / 512);
         2: begin
            if (dir == 0) begin
               if (cur >= 512) begin
                  dir = 1;
                  cur = cur / 2;
               end else begin
                  cur = cur * 2;
               end
            end else begin
               if (cur % 2 == 1) begin
                  dir = 0;
                  cur = (cur * 2) % 1024;
               end else begin
                  cur = cur / 2;
               end
            end
         end
         default: cur = (cur != 0) ? 0 : seed;
      endcase
   endfunction

   typedef struct {
      logic [1:0]  addr;
      logic        wr;
      logic [31:0] data;
      logic [1:0]  raddr;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int c, d, m, sd, pr, n;

      bus.s_address    = '0;
      bus.s_chipselect = 1'b0;
      bus.s_write_n    = 1'b1;
      bus.s_writedata  = '0;
      reset_n = 1'b0;
      step(3);
      reset_n = 1'b1;
      step();

      chk("rst_cs", bus.m_chipselect, 1'b0);
      chk("rst_write_n", bus.m_write_n, 1'b1);
      chk("rst_wdata", bus.m_writedata, 32'h0);
      chk("m_address", bus.m_address, 2'd0);
      reg_read(2'd3, rd);
      chk("rst_status", rd, 32'h0255_0000);
      reg_read(2'd2, rd);
      chk("rst_seed", rd, 32'h0000_0255);

      tbl[0] = '{2'd0, 1'b1, 32'h0000_0006, 2'd0, 32'h0000_0006};
      tbl[1] = '{2'd0, 1'b1, 32'hFFFF_FFF8, 2'd0, 32'h0000_0000};
      tbl[2] = '{2'd1, 1'b1, 32'hFFFF_FFFF, 2'd1, 32'h00FF_FFFF};
      tbl[3] = '{2'd1, 1'b1, 32'h0000_0007, 2'd1, 32'h0000_0007};
      tbl[4] = '{2'd2, 1'b1, 32'hFFFF_FFFF, 2'd2, 32'h0000_03FF};
      tbl[5] = '{2'd0, 1'b0, 32'h0000_0000, 2'd3, 32'h03FF_0000};
      tbl[6] = '{2'd3, 1'b1, 32'hFFFF_FFFF, 2'd3, 32'h03FF_0000};
      tbl[7] = '{2'd2, 1'b1, 32'h0000_00A5, 2'd3, 32'h00A5_0000};
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].wr) reg_write(tbl[i].addr, tbl[i].data);
         reg_read(tbl[i].raddr, rd);
         chk($sformatf("tbl%0d", i), rd, tbl[i].exp);
      end
      chk("tbl_idle_cs", bus.m_chipselect, 1'b0);

      // ROTATE, PERIOD=3: one-hot walk with 6-cycle spacing
      acc_q.delete();
      acc_cyc.delete();
      reg_write(2'd1, 32'd3);
      reg_write(2'd2, 32'h001);
      reg_write(2'd0, 32'h3);
      wait_acc(11, 200);
      c = 1;
      d = 0;
      for (int i = 0; i < 11 && i < acc_q.size(); i++) begin
         chk($sformatf("rot_val%0d", i), acc_q[i], c);
         model_step(1, c, d, 1);
      end
      for (int i = 1; i < 11 && i < acc_cyc.size(); i++)
         chk($sformatf("rot_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 6);
      stop_seq();

      // BOUNCE from 0x100, direction flips leaving 0x200
      reg_write(2'd1, 32'd5);
      reg_write(2'd2, 32'h100);
      reg_write(2'd0, 32'h5);
      wait_acc(2, 100);
      reg_read(2'd3, rd);
      chk("bnc_status_at_200", rd, 32'h0200_0001);
      wait_acc(3, 100);
      reg_read(2'd3, rd);
      chk("bnc_status_dir", rd, 32'h0100_0003);
      wait_acc(4, 100);
      c = 'h100;
      d = 0;
      for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
         chk($sformatf("bnc_val%0d", i), acc_q[i], c);
         model_step(2, c, d, 'h100);
      end
      stop_seq();

      // BLINK, PERIOD=0
      reg_write(2'd1, 32'd0);
      reg_write(2'd2, 32'h3FF);
      reg_write(2'd0, 32'h7);
      wait_acc(4, 100);
      for (int i = 0; i < 4 && i < acc_q.size(); i++)
         chk($sformatf("blink_val%0d", i), acc_q[i], (i % 2 == 0) ? 32'h3FF : 32'h0);
      for (int i = 1; i < 4 && i < acc_cyc.size(); i++)
         chk($sformatf("blink_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
      stop_seq();

      // stalled write with a SEED update in flight
      wr_mode = 2;
      reg_write(2'd1, 32'd2);
      reg_write(2'd2, 32'h003);
      reg_write(2'd0, 32'h3);
      wait_cs(20);
      chk("stall_wd0", bus.m_writedata, 32'h003);
      step(2);
      reg_write(2'd2, 32'h030);
      step(2);
      chk("stall_wd1", bus.m_writedata, 32'h003);
      reg_read(2'd2, rd);
      chk("stall_seed_reg", rd, 32'h030);
      reg_read(2'd3, rd);
      chk("stall_cur_held", rd, 32'h0003_0001);
      wr_mode = 0;
      wait_acc(2, 100);
      chk("stall_acc0", acc_q.size() > 0 ? acc_q[0] : 32'hDEAD, 32'h003);
      chk("stall_acc1", acc_q.size() > 1 ? acc_q[1] : 32'hDEAD, 32'h060);
      stop_seq();

      // enable cleared while a write is pending
      wr_mode = 2;
      reg_write(2'd2, 32'h011);
      reg_write(2'd0, 32'h3);
      wait_cs(20);
      reg_write(2'd0, 32'h2);
      chk("dis_cs_pending", bus.m_chipselect, 1'b1);
      wr_mode = 0;
      wait_acc(1, 50);
      step();
      reg_read(2'd3, rd);
      chk("dis_status", rd, 32'h0011_0000);
      chk("dis_cs_idle", bus.m_chipselect, 1'b0);
      step(10);
      chk("dis_count", acc_q.size(), 1);
      chk("dis_acc0", acc_q.size() > 0 ? acc_q[0] : 32'hDEAD, 32'h011);
      stop_seq();

      // asynchronous reset during a stalled write
      wr_mode = 2;
      reg_write(2'd0, 32'h3);
      wait_cs(20);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_cs", bus.m_chipselect, 1'b0);
      chk("arst_write_n", bus.m_write_n, 1'b1);
      chk("arst_wdata", bus.m_writedata, 32'h0);
      wr_mode = 0;
      step();
      reset_n = 1'b1;
      step();
      reg_read(2'd3, rd);
      chk("arst_status", rd, 32'h0255_0000);
      reg_read(2'd0, rd);
      chk("arst_ctrl", rd, 32'h0);

      // reset while waiting for a tick
      acc_q.delete();
      acc_cyc.delete();
      reg_write(2'd1, 32'd20);
      reg_write(2'd2, 32'h081);
      reg_write(2'd0, 32'h3);
      wait_acc(1, 50);
      step(3);
      reg_read(2'd3, rd);
      chk("wrst_before", rd, 32'h0081_0001);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      reg_read(2'd3, rd);
      chk("wrst_status", rd, 32'h0255_0000);
      reg_read(2'd1, rd);
      chk("wrst_period", rd, 32'h0);
      chk("wrst_cs", bus.m_chipselect, 1'b0);

      // switch to STATIC mid-run: one write back to SEED, then quiet
      acc_q.delete();
      acc_cyc.delete();
      reg_write(2'd1, 32'd1);
      reg_write(2'd2, 32'h001);
      reg_write(2'd0, 32'h3);
      wait_acc(3, 100);
      reg_write(2'd0, 32'h1);
      step(40);
      chk("static_last", acc_q.size() > 0 ? acc_q[acc_q.size()-1] : 32'hDEAD, 32'h001);
      n = acc_q.size();
      step(30);
      chk("static_quiet", acc_q.size(), n);
      reg_read(2'd3, rd);
      chk("static_status", rd, 32'h0001_0001);
      stop_seq();

      // randomized modes, seeds, periods and stalls
      for (int t = 0; t < 6; t++) begin
         m  = $urandom_range(1, 3);
         sd = $urandom_range(0, 1023);
         pr = $urandom_range(0, 3);
         wr_mode = $urandom_range(0, 1);
         reg_write(2'd1, pr);
         reg_write(2'd2, sd);
         reg_write(2'd0, (m << 1) | 1);
         wait_acc(8, 400);
         c = sd;
         d = 0;
         for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
            chk($sformatf("rand%0d_m%0d_val%0d", t, m, i), acc_q[i], c);
            model_step(m, c, d, sd);
         end
         stop_seq();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
